alu_issue_ctrl: RTL

Initiator-side controller for the register-file/ALU datapath. It accepts 32-bit RV32I instruction words over a valid/ready handshake and decodes them. It then drives the datapath control interface: rs1, rs2, rd, en, ALUSrc, ImmOp and ALU_ctrl. It consumes the datapath's eq flag to resolve BEQ/BNE, maintains the PC and counts retired instructions. Together with the datapath it forms a minimal multi-cycle core.

---
 rtl/alu_issue_pkg.sv | 26 ++
 rtl/alu_issue_ctrl_decode.sv | 95 +++++++++
 rtl/alu_issue_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/alu_issue_pkg.sv
// Shared encodings for the ALU issue controller: ALU operation select,
// RV32I opcode constants and the controller state enum.
package alu_issue_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_SLT = 4'd7
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    TRAP  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_issue_ctrl_decode.sv
// Combinational RV32I subset decoder: OP, OP-IMM and BEQ/BNE; everything
// else is flagged illegal with the write enable held low.
module alu_issue_ctrl_decode
  import alu_issue_pkg::*;
#(
  parameter int Address_Width = 5,
  parameter int Data_Width    = 32
) (
  input  logic [31:0]              ir,
  output logic [Address_Width-1:0] rs1,
  output logic [Address_Width-1:0] rs2,
  output logic [Address_Width-1:0] rd,
  output logic                     we,
  output logic                     alu_src,
  output logic [Data_Width-1:0]    imm,
  output logic [3:0]               alu_ctrl,
  output logic                     is_branch,
  output logic                     is_bne,
  output logic                     illegal
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic       w_wb;

  assign w_opcode = ir[6:0];
  assign w_funct3 = ir[14:12];
  assign w_funct7 = ir[31:25];

  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];
  assign rd  = ir[11:7];

  always_comb begin
    w_wb      = 1'b0;
    alu_src   = 1'b0;
    imm       = '0;
    alu_ctrl  = ALU_ADD;
    is_branch = 1'b0;
    is_bne    = 1'b0;
    illegal   = 1'b1;
    case (w_opcode)
      OPC_OP: begin
        w_wb = 1'b1;
        if (w_funct7 == 7'b0000000) begin
          illegal = 1'b0;
          case (w_funct3)
            3'b000:  alu_ctrl = ALU_ADD;
            3'b111:  alu_ctrl = ALU_AND;
            3'b110:  alu_ctrl = ALU_OR;
            3'b100:  alu_ctrl = ALU_XOR;
            3'b001:  alu_ctrl = ALU_SLL;
            3'b101:  alu_ctrl = ALU_SRL;
            3'b010:  alu_ctrl = ALU_SLT;
            default: illegal  = 1'b1;
          endcase
        end else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b000) begin
          illegal  = 1'b0;
          alu_ctrl = ALU_SUB;
        end
      end
      OPC_OP_IMM: begin
        w_wb    = 1'b1;
        alu_src = 1'b1;
        imm     = {{(Data_Width-12){ir[31]}}, ir[31:20]};
        illegal = 1'b0;
        case (w_funct3)
          3'b000: alu_ctrl = ALU_ADD;
          3'b111: alu_ctrl = ALU_AND;
          3'b110: alu_ctrl = ALU_OR;
          3'b100: alu_ctrl = ALU_XOR;
          3'b010: alu_ctrl = ALU_SLT;
          // Shifts take a zero-extended 5-bit shamt; SRAI (funct7 0100000) is not supported
          3'b001, 3'b101: begin
            alu_ctrl = (w_funct3 == 3'b001) ? ALU_SLL : ALU_SRL;
            imm      = {{(Data_Width-5){1'b0}}, ir[24:20]};
            illegal  = (w_funct7 != 7'b0000000);
          end
          default: illegal = 1'b1;
        endcase
      end
      OPC_BRANCH: begin
        alu_ctrl  = ALU_SUB;
        is_branch = 1'b1;
        is_bne    = (w_funct3 == 3'b001);
        illegal   = (w_funct3 != 3'b000) && (w_funct3 != 3'b001);
      end
      default: illegal = 1'b1;
    endcase
  end

  assign we = w_wb && !illegal && (rd != '0);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue controller: fetches one instruction word per FETCH/EXEC
// pair, drives the register-file/ALU controls in EXEC and updates pc/retired.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int Address_Width = 5,
  parameter int Data_Width    = 32,
  parameter int PC_Width      = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     instr_valid,
  input  logic [31:0]              instr,
  output logic                     instr_ready,
  output logic [PC_Width-1:0]      pc,
  output logic [Address_Width-1:0] rs1,
  output logic [Address_Width-1:0] rs2,
  output logic [Address_Width-1:0] rd,
  output logic                     en,
  output logic                     ALUSrc,
  output logic [Data_Width-1:0]    ImmOp,
  output logic [3:0]               ALU_ctrl,
  input  logic                     eq,
  output logic                     trap,
  output logic [31:0]              retired
);

  state_e                r_state;
  logic [PC_Width-1:0]   r_pc;
  logic [31:0]           r_ir;
  logic [31:0]           r_retired;
  logic                  r_trap;

  logic [Address_Width-1:0] w_rs1, w_rs2, w_rd;
  logic                     w_we, w_alu_src, w_is_branch, w_is_bne, w_illegal;
  logic [Data_Width-1:0]    w_imm;
  logic [3:0]               w_alu_ctrl;
  logic                     w_exec, w_taken;
  logic [PC_Width-1:0]      w_br_off;

  alu_issue_ctrl_decode #(
    .Address_Width (Address_Width),
    .Data_Width    (Data_Width)
  ) u_decode (
    .ir        (r_ir),
    .rs1       (w_rs1),
    .rs2       (w_rs2),
    .rd        (w_rd),
    .we        (w_we),
    .alu_src   (w_alu_src),
    .imm       (w_imm),
    .alu_ctrl  (w_alu_ctrl),
    .is_branch (w_is_branch),
    .is_bne    (w_is_bne),
    .illegal   (w_illegal)
  );

  // Datapath controls are only live in EXEC; state is async-reset so en drops with rst_n
  assign w_exec      = (r_state == EXEC);
  assign instr_ready = rst_n && (r_state == FETCH);
  assign en          = w_exec && w_we;
  assign rs1         = w_exec ? w_rs1 : '0;
  assign rs2         = w_exec ? w_rs2 : '0;
  assign rd          = w_exec ? w_rd : '0;
  assign ALUSrc      = w_exec && w_alu_src;
  assign ImmOp       = w_exec ? w_imm : '0;
  assign ALU_ctrl    = w_exec ? w_alu_ctrl : ALU_ADD;

  assign pc      = r_pc;
  assign trap    = r_trap;
  assign retired = r_retired;

  assign w_taken  = w_is_branch && (w_is_bne ? !eq : eq);
  assign w_br_off = {{(PC_Width-13){r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= FETCH;
      r_pc      <= '0;
      r_ir      <= '0;
      r_retired <= '0;
      r_trap    <= 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          if (instr_valid) begin
            r_ir    <= instr;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          if (w_illegal) begin
            r_trap  <= 1'b1;
            r_state <= TRAP;
          end else begin
            r_pc      <= w_taken ? (r_pc + w_br_off) : (r_pc + PC_Width'(4));
            r_retired <= r_retired + 32'd1;
            r_state   <= FETCH;
          end
        end
        TRAP:    r_state <= TRAP;
        default: r_state <= TRAP;
      endcase
    end
  end

endmodule
